// File: rtl/spi_tx_sched.sv
// Transmit scheduler for the SPI slave link: buffers one word per measurement
// channel, arbitrates round-robin and holds the granted word stable for a frame.
module spi_tx_sched #(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 16,
  parameter int unsigned CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    meas_done,
  input  logic [NCH*DW-1:0] meas_data,
  input  logic              spi_cs_n,
  input  logic              ovr_clr,
  output logic [DW-1:0]     txd_data,
  output logic [CW-1:0]     tx_ch,
  output logic              mcu_irq,
  output logic              frame_done,
  output logic [NCH-1:0]    overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

  state_t          state;
  logic [DW-1:0]   pbuf [NCH];
  logic [NCH-1:0]  pend;
  logic [CW-1:0]   last;
  logic            cs_meta, cs_s, cs_d;
  logic            cs_fall_c, cs_rise_c;
  logic            grant_c, found_c;
  logic [CW-1:0]   gnt_idx_c, idx_c;
  logic [NCH-1:0]  ovr_new_c;

  // CS synchronizer plus edge-detect flop; idles high so reset looks like "no frame"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
      cs_d    <= 1'b1;
    end else begin
      cs_meta <= spi_cs_n;
      cs_s    <= cs_meta;
      cs_d    <= cs_s;
    end
  end

  assign cs_fall_c = cs_d & ~cs_s;
  assign cs_rise_c = ~cs_d & cs_s;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    found_c   = 1'b0;
    gnt_idx_c = '0;
    idx_c     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx_c = CW'((32'(last) + 32'd1 + k) % NCH);
      if (!found_c && pend[idx_c]) begin
        found_c   = 1'b1;
        gnt_idx_c = idx_c;
      end
    end
  end

  assign grant_c = (state == IDLE) && cs_s && found_c;

  // A strobe on the channel being granted this cycle refills it without overrun
  always_comb begin
    ovr_new_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ovr_new_c[i] = meas_done[i] & pend[i] & ~(grant_c && (gnt_idx_c == CW'(i)));
    end
  end

  // Per-channel capture, independent of the frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      overrun <= '0;
      for (int unsigned i = 0; i < NCH; i++) pbuf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (meas_done[i]) begin
          pbuf[i] <= meas_data[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (grant_c && (gnt_idx_c == CW'(i))) begin
          pend[i] <= 1'b0;
        end
      end
      overrun <= (overrun & ~{NCH{ovr_clr}}) | ovr_new_c;
    end
  end

  // Frame FSM: load on grant, hold through the frame, clear at CS rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      txd_data   <= '0;
      tx_ch      <= '0;
      mcu_irq    <= 1'b0;
      frame_done <= 1'b0;
      last       <= CW'(NCH - 1);
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          txd_data <= '0;
          mcu_irq  <= 1'b0;
          if (grant_c) begin
            txd_data <= pbuf[gnt_idx_c];
            tx_ch    <= gnt_idx_c;
            last     <= gnt_idx_c;
            mcu_irq  <= 1'b1;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (cs_fall_c) begin
            mcu_irq <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cs_rise_c) begin
            txd_data   <= '0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
